// File: rtl/conv_row_scheduler.sv
// -----------------------------------------------------------------------------
// conv_row_scheduler
//
// Sequencer for the half-row convolution array. It walks the output map one
// half-row ("chunk") at a time, clears the NCU conv units, holds the clear low
// for their D*F*F+2-cycle accumulation window, captures the half-row result and
// streams it out over a valid/ready port. It sits between the layer controller
// (start/done) and the receptive-field selector plus conv units.
//
// Optional feature (macro CONV_SCHED_PERF_EN):
//   adds perf_stall, a saturating count of EMIT cycles stalled by backpressure.
//
// Ports:
//   clk        in   1               clock, rising edge
//   reset      in   1               asynchronous, active-low reset
//   start      in   1               begin a layer (only looked at in IDLE)
//   busy       out  1               high in every state except IDLE
//   done       out  1               one-cycle pulse after the final chunk handshake
//   cu_clear   out  1               active-high clear to all conv units
//   row_idx    out  11              input row of the current receptive fields
//   col_base   out  11              output column offset, 0 or NCU
//   cu_result  in   NCU*DATA_WIDTH  conv unit results, unit 0 in the MSBs
//   out_valid  out  1               out_data/out_index valid
//   out_ready  in   1               consumer accepts the chunk
//   out_data   out  NCU*DATA_WIDTH  registered half-row result
//   out_index  out  16              chunk number, 2*row + half
//   perf_stall out  32              (CONV_SCHED_PERF_EN only) stalled EMIT cycles
//
// The output width OW=(W-F)/S+1 must be even so the row splits into two halves.
// -----------------------------------------------------------------------------
module conv_row_scheduler #(
    parameter  int D          = 1,
    parameter  int H          = 32,
    parameter  int W          = 32,
    parameter  int F          = 5,
    parameter  int S          = 1,
    parameter  int DATA_WIDTH = 16,
    localparam int OH         = (H - F) / S + 1,
    localparam int OW         = (W - F) / S + 1,
    localparam int NCU        = OW / 2,
    localparam int LAT        = D * F * F + 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      cu_clear,
    output logic [10:0]               row_idx,
    output logic [10:0]               col_base,
    input  logic [NCU*DATA_WIDTH-1:0] cu_result,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NCU*DATA_WIDTH-1:0] out_data,
    output logic [15:0]               out_index
`ifdef CONV_SCHED_PERF_EN
    ,
    output logic [31:0]               perf_stall
`endif
);

    localparam int              CNT_W    = $clog2(LAT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);
    localparam logic [10:0]     ROW_LAST = 11'((OH - 1) * S);
    localparam logic [10:0]     COL_HI   = 11'(NCU);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COMPUTE,
        S_EMIT,
        S_DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              last_chunk;

    assign last_chunk = (row_idx == ROW_LAST) && (col_base == COL_HI);

    // NOTE: every register here uses non-blocking assignments so each one
    // samples pre-edge values regardless of statement order in the block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cu_clear  <= 1'b1;
            row_idx   <= '0;
            col_base  <= '0;
            out_valid <= 1'b0;
            // NOTE: out_data is a plain register, not a memory array, so it is
            // cheap to reset and gives the consumer a defined value.
            out_data  <= '0;
            out_index <= '0;
        end else begin
            // NOTE: done defaults low every cycle, making it a single-cycle pulse
            // without needing an explicit clear in each state.
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_CLEAR;
                        busy      <= 1'b1;
                        cu_clear  <= 1'b1;
                        row_idx   <= '0;
                        col_base  <= '0;
                        out_index <= '0;
                    end
                end
                S_CLEAR: begin
                    cnt      <= '0;
                    cu_clear <= 1'b0;
                    state    <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    // Results are final on the LAT-th accumulation cycle.
                    if (cnt == CNT_LAST) begin
                        out_data  <= cu_result;
                        out_valid <= 1'b1;
                        cu_clear  <= 1'b1;
                        state     <= S_EMIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_chunk) begin
                            // Position and index freeze on the final chunk so
                            // row_idx never steps past the last output row.
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            out_index <= out_index + 16'd1;
                            if (col_base == '0) begin
                                col_base <= COL_HI;
                            end else begin
                                col_base <= '0;
                                row_idx  <= row_idx + 11'(S);
                            end
                            state <= S_CLEAR;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CONV_SCHED_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall <= '0;
        end else if (state == S_IDLE && start) begin
            perf_stall <= '0;
        end else if (state == S_EMIT && out_valid && !out_ready && perf_stall != '1) begin
            perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_row_scheduler.sv
// -----------------------------------------------------------------------------
// tb_conv_row_scheduler
//
// Directed bench for conv_row_scheduler. One DUT uses the default geometry
// (OH=28, NCU=14, LAT=27 -> 29-cycle chunks, 56 chunks per layer); a second
// uses H=6, W=8, F=5, S=1, D=2 (OH=2, NCU=2, LAT=52 -> 54-cycle chunks).
// cu_result is driven from the DUT's own row_idx/col_base so every captured
// chunk carries its position; the bench derives the expected word from its
// own chunk count. Elapsed times count rising edges after the edge that
// samples start.
// -----------------------------------------------------------------------------
module tb_conv_row_scheduler;

    localparam int DW       = 16;
    localparam int NCU      = 14;
    localparam int N_CHUNKS = 56;
    localparam int CHUNK    = 29;             // LAT + 2
    localparam int FIRST    = 28;             // CLEAR + LAT cycles before first valid
    localparam int LAYER    = N_CHUNKS * CHUNK;

    localparam int SNCU     = 2;
    localparam int S_CHUNKS = 4;
    localparam int S_CHUNK  = 54;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic                out_ready;
    logic                busy, done, cu_clear, out_valid;
    logic [10:0]         row_idx, col_base;
    logic [NCU*DW-1:0]   cu_result, out_data;
    logic [15:0]         out_index;

    logic                s_start, s_ready;
    logic                s_busy, s_done, s_cu_clear, s_valid;
    logic [10:0]         s_row_idx, s_col_base;
    logic [SNCU*DW-1:0]  s_cu_result, s_data;
    logic [15:0]         s_index;

`ifdef CONV_SCHED_PERF_EN
    logic [31:0]         perf_stall, s_perf_stall;
`endif

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_row_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .cu_clear  (cu_clear),
        .row_idx   (row_idx),
        .col_base  (col_base),
        .cu_result (cu_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index)
`ifdef CONV_SCHED_PERF_EN
        ,
        .perf_stall(perf_stall)
`endif
    );

    conv_row_scheduler #(.D(2), .H(6), .W(8), .F(5), .S(1), .DATA_WIDTH(16)) dut_s (
        .clk       (clk),
        .reset     (reset),
        .start     (s_start),
        .busy      (s_busy),
        .done      (s_done),
        .cu_clear  (s_cu_clear),
        .row_idx   (s_row_idx),
        .col_base  (s_col_base),
        .cu_result (s_cu_result),
        .out_valid (s_valid),
        .out_ready (s_ready),
        .out_data  (s_data),
        .out_index (s_index)
`ifdef CONV_SCHED_PERF_EN
        ,
        .perf_stall(s_perf_stall)
`endif
    );

    // Each conv unit reports {row, column} of its receptive field.
    always_comb begin
        cu_result = '0;
        for (int k = 0; k < NCU; k++)
            cu_result[(NCU-1-k)*DW +: DW] = {row_idx[7:0], col_base[7:0] + 8'(k)};
    end

    always_comb begin
        s_cu_result = '0;
        for (int k = 0; k < SNCU; k++)
            s_cu_result[(SNCU-1-k)*DW +: DW] = {s_row_idx[7:0], s_col_base[7:0] + 8'(k)};
    end

    function automatic logic [NCU*DW-1:0] exp_data(input int n);
        logic [NCU*DW-1:0] v;
        logic [7:0]        r, c;
        r = 8'(n / 2);
        c = 8'((n % 2) * NCU);
        for (int k = 0; k < NCU; k++) v[(NCU-1-k)*DW +: DW] = {r, c + 8'(k)};
        return v;
    endfunction

    function automatic logic [SNCU*DW-1:0] exp_data_s(input int n);
        logic [SNCU*DW-1:0] v;
        logic [7:0]         r, c;
        r = 8'(n / 2);
        c = 8'((n % 2) * SNCU);
        for (int k = 0; k < SNCU; k++) v[(SNCU-1-k)*DW +: DW] = {r, c + 8'(k)};
        return v;
    endfunction

    // Runs one default-geometry layer. Optionally stalls chunk stall_chunk for
    // stall_len cycles and pulses start during COMPUTE of chunk poke_chunk.
    task automatic run_layer(input int stall_chunk, input int stall_len, input int poke_chunk,
                             output int chunks, output int done_t);
        int t0, last_rise, stalled, exp_gap, got_gap;
        bit seen, poked, finished;
        chunks = 0; done_t = -1; stalled = 0; last_rise = 0;
        seen = 0; poked = 0; finished = 0;
        @(negedge clk); start = 1'b1; out_ready = 1'b1;
        @(negedge clk); start = 1'b0; t0 = cyc;
        for (int i = 0; i < 4000 && !finished; i++) begin
            start = 1'b0;
            if (done) begin
                done_t   = cyc - t0;
                finished = 1;
            end else if (out_valid) begin
                if (!seen) begin
                    seen    = 1;
                    exp_gap = (chunks == 0) ? FIRST
                            : CHUNK + ((chunks - 1 == stall_chunk) ? stall_len : 0);
                    got_gap = cyc - ((chunks == 0) ? t0 : last_rise);
                    last_rise = cyc;
                    compared++;
                    if (got_gap != exp_gap) begin
                        mismatched++;
                        $display("FAIL valid_gap chunk %0d: got %0d expected %0d", chunks, got_gap, exp_gap);
                    end
                    compared++;
                    if (row_idx !== 11'(chunks / 2) || col_base !== 11'((chunks % 2) * NCU)) begin
                        mismatched++;
                        $display("FAIL position chunk %0d: got row %0d col %0d expected row %0d col %0d",
                                 chunks, row_idx, col_base, chunks / 2, (chunks % 2) * NCU);
                    end
                end
                compared++;
                if (out_index !== 16'(chunks)) begin
                    mismatched++;
                    $display("FAIL out_index: got %0d expected %0d", out_index, chunks);
                end
                compared++;
                if (out_data !== exp_data(chunks)) begin
                    mismatched++;
                    $display("FAIL out_data chunk %0d: got %h expected %h", chunks, out_data, exp_data(chunks));
                end
                compared++;
                if (cu_clear !== 1'b1) begin
                    mismatched++;
                    $display("FAIL cu_clear_emit chunk %0d: got %b expected 1", chunks, cu_clear);
                end
                if (chunks == stall_chunk && stalled < stall_len) begin
                    out_ready = 1'b0;
                    stalled++;
                end else begin
                    out_ready = 1'b1;
                    chunks++;
                    seen = 0;
                end
            end else if (chunks == poke_chunk && !poked && !cu_clear && busy) begin
                start = 1'b1;
                poked = 1;
            end
            if (!finished) @(negedge clk);
        end
        compared++;
        if (!finished) begin
            mismatched++;
            $display("FAIL layer_timeout: got no done expected done within 4000 cycles");
        end else begin
            @(negedge clk);
            compared++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                mismatched++;
                $display("FAIL after_done: got done %b busy %b expected 0 0", done, busy);
            end
            compared++;
            if (row_idx !== 11'd27 || col_base !== 11'd14 || out_index !== 16'd55) begin
                mismatched++;
                $display("FAIL final_position: got row %0d col %0d idx %0d expected 27 14 55",
                         row_idx, col_base, out_index);
            end
        end
        if (poke_chunk >= 0) begin
            compared++;
            if (!poked) begin
                mismatched++;
                $display("FAIL start_poke: got no COMPUTE cycle at chunk %0d expected one", poke_chunk);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        compared++;
        if (busy !== 1'b0 || done !== 1'b0 || cu_clear !== 1'b1 || out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL %s_ctrl: got busy %b done %b clr %b valid %b expected 0 0 1 0",
                     tag, busy, done, cu_clear, out_valid);
        end
        compared++;
        if (row_idx !== '0 || col_base !== '0 || out_index !== '0 || out_data !== '0) begin
            mismatched++;
            $display("FAIL %s_data: got row %0d col %0d idx %0d data %h expected all 0",
                     tag, row_idx, col_base, out_index, out_data);
        end
`ifdef CONV_SCHED_PERF_EN
        compared++;
        if (perf_stall !== 32'd0) begin
            mismatched++;
            $display("FAIL %s_perf: got %0d expected 0", tag, perf_stall);
        end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; out_ready = 1'b0; s_start = 1'b0; s_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("idle");
    endtask

    task automatic test_full_layer();
        int ch, dt;
        run_layer(-1, 0, -1, ch, dt);
        compared++;
        if (ch != N_CHUNKS || dt != LAYER) begin
            mismatched++;
            $display("FAIL full_layer: got %0d chunks done at %0d expected %0d at %0d", ch, dt, N_CHUNKS, LAYER);
        end
    endtask

    task automatic test_backpressure();
        int ch, dt;
        run_layer(3, 10, -1, ch, dt);
        compared++;
        if (ch != N_CHUNKS || dt != LAYER + 10) begin
            mismatched++;
            $display("FAIL backpressure: got %0d chunks done at %0d expected %0d at %0d",
                     ch, dt, N_CHUNKS, LAYER + 10);
        end
`ifdef CONV_SCHED_PERF_EN
        compared++;
        if (perf_stall !== 32'd10) begin
            mismatched++;
            $display("FAIL perf_stall: got %0d expected 10", perf_stall);
        end
`endif
    endtask

    task automatic test_start_while_busy();
        int ch, dt;
        run_layer(-1, 0, 5, ch, dt);
        compared++;
        if (ch != N_CHUNKS || dt != LAYER) begin
            mismatched++;
            $display("FAIL start_busy: got %0d chunks done at %0d expected %0d at %0d", ch, dt, N_CHUNKS, LAYER);
        end
`ifdef CONV_SCHED_PERF_EN
        compared++;
        if (perf_stall !== 32'd0) begin
            mismatched++;
            $display("FAIL perf_cleared: got %0d expected 0", perf_stall);
        end
`endif
    endtask

    task automatic test_reset_abort();
        int n, k, bad, ch, dt;
        n = 0; k = 0; bad = 0;
        @(negedge clk); start = 1'b1; out_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 1000 && k < 10; i++) begin
            if (out_valid) n++;
            if (n == 7 && !cu_clear && !out_valid) k++;
            if (k < 10) @(negedge clk);
        end
        compared++;
        if (k != 10) begin
            mismatched++;
            $display("FAIL abort_reach: got %0d chunks expected to reach COMPUTE of chunk 7", n);
        end
        reset = 1'b0;
        #1;
        check_reset_values("abort");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid || busy) bad++;
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL abort_quiet: got %0d active cycles expected 0", bad);
        end
        run_layer(-1, 0, -1, ch, dt);
        compared++;
        if (ch != N_CHUNKS || dt != LAYER) begin
            mismatched++;
            $display("FAIL abort_restart: got %0d chunks done at %0d expected %0d at %0d", ch, dt, N_CHUNKS, LAYER);
        end
    endtask

    task automatic test_small_config();
        int t0, last, n, gap, exp_gap, dt;
        n = 0; dt = -1; last = 0;
        @(negedge clk); s_start = 1'b1; s_ready = 1'b1;
        @(negedge clk); s_start = 1'b0; t0 = cyc;
        for (int i = 0; i < 600 && dt < 0; i++) begin
            if (s_done) begin
                dt = cyc - t0;
            end else if (s_valid) begin
                exp_gap = (n == 0) ? S_CHUNK - 1 : S_CHUNK;
                gap     = cyc - ((n == 0) ? t0 : last);
                last    = cyc;
                compared++;
                if (gap != exp_gap || s_index !== 16'(n) || s_data !== exp_data_s(n)) begin
                    mismatched++;
                    $display("FAIL small_chunk %0d: got gap %0d idx %0d data %h expected %0d %0d %h",
                             n, gap, s_index, s_data, exp_gap, n, exp_data_s(n));
                end
                n++;
            end
            if (dt < 0) @(negedge clk);
        end
        compared++;
        if (n != S_CHUNKS || dt != S_CHUNKS * S_CHUNK) begin
            mismatched++;
            $display("FAIL small_layer: got %0d chunks done at %0d expected %0d at %0d",
                     n, dt, S_CHUNKS, S_CHUNKS * S_CHUNK);
        end
        @(negedge clk);
        compared++;
        if (s_busy !== 1'b0 || s_row_idx !== 11'd1 || s_col_base !== 11'd2 || s_index !== 16'd3) begin
            mismatched++;
            $display("FAIL small_final: got busy %b row %0d col %0d idx %0d expected 0 1 2 3",
                     s_busy, s_row_idx, s_col_base, s_index);
        end
    endtask

    initial begin
        test_reset();
        test_full_layer();
        test_backpressure();
        test_start_while_busy();
        test_reset_abort();
        test_small_config();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
